// File: rtl/if_fetch_buffer.sv
// Fetch stage: requests instruction memory at the current PC and queues responses for decode.
// Optional macro FETCH_BUF_BYPASS_EN forwards a response straight to decode when the queue is empty.
module if_fetch_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pc,
  output logic             o_stall,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic [31:0]      i_imem_rdata,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [31:0]      o_instr,
  output logic [WIDTH-1:0] o_instr_pc,
  input  logic             i_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]      instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             inflight_q;
  logic [WIDTH-1:0] inflight_pc_q;
  logic [CW:0]      occ;
  logic             full;
  logic             bypass;
  logic             push;
  logic             fifo_pop;

  // A slot is reserved at request time, so occupancy counts the in-flight fetch.
  assign occ  = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign full = occ >= (CW+1)'(DEPTH);

  assign o_stall     = !i_rst & !i_flush & full;
  assign o_imem_req  = !i_rst & !i_flush & !full;
  assign o_imem_addr = i_pc;

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = (count == '0) & inflight_q;
`else
  assign bypass = 1'b0;
`endif

  assign o_valid    = !i_rst & !i_flush & ((count != '0) | bypass);
  assign o_instr    = bypass ? i_imem_rdata : instr_mem[rd_ptr];
  assign o_instr_pc = bypass ? inflight_pc_q : pc_mem[rd_ptr];

  assign fifo_pop = o_valid & i_ready & !bypass;
  assign push     = inflight_q & !i_flush & !(bypass & i_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= o_imem_req;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case (1'b1)
        push & !fifo_pop: count <= count + CW'(1);
        fifo_pop & !push: count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (o_imem_req) begin
      inflight_pc_q <= i_pc;
    end
    if (push && !i_rst) begin
      instr_mem[wr_ptr] <= i_imem_rdata;
      pc_mem[wr_ptr]    <= inflight_pc_q;
    end
  end

endmodule
